// File: rtl/alu_scheduler.sv
// Round-robin scheduler sharing one combinational 4-bit ALU between two requesters.
// Operands are held on the ALU for LAT cycles, then OUT/Z/CF are captured and returned.
module alu_scheduler #(
  parameter int unsigned LAT = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic [2:0] OP0,
  input  logic [2:0] OP1,
  input  logic [3:0] A0,
  input  logic [3:0] B0,
  input  logic [3:0] A1,
  input  logic [3:0] B1,
  output logic [2:0] ALU_SEL,
  output logic [3:0] ALU_A,
  output logic [3:0] ALU_B,
  input  logic [3:0] ALU_OUT,
  input  logic       ALU_Z,
  input  logic       ALU_CF,
  output logic       GNT0,
  output logic       GNT1,
  output logic       DONE0,
  output logic       DONE1,
  output logic [3:0] RES,
  output logic       RES_Z,
  output logic       RES_CF,
  output logic       BUSY,
  output logic [7:0] OP_CNT
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_q, last_d;
  logic       win_q, win_d;
  logic [2:0] sel_q, sel_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic       gnt0_q, gnt0_d;
  logic       gnt1_q, gnt1_d;
  logic       done0_q, done0_d;
  logic       done1_q, done1_d;
  logic [3:0] res_q, res_d;
  logic       res_z_q, res_z_d;
  logic       res_cf_q, res_cf_d;
  logic       busy_q, busy_d;
  logic [7:0] op_cnt_q, op_cnt_d;
  logic       pick1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    win_d    = win_q;
    sel_d    = sel_q;
    a_d      = a_q;
    b_d      = b_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    res_d    = res_q;
    res_z_d  = res_z_q;
    res_cf_d = res_cf_q;
    op_cnt_d = op_cnt_q;
    // Requester 1 wins alone, or on contention when requester 0 was served last.
    pick1    = REQ1 & (~REQ0 | ~last_q);
    case (state_q)
      IDLE: begin
        sel_d = '0;
        a_d   = '0;
        b_d   = '0;
        if (REQ0 || REQ1) begin
          win_d   = pick1;
          last_d  = pick1;
          sel_d   = pick1 ? OP1 : OP0;
          a_d     = pick1 ? A1 : A0;
          b_d     = pick1 ? B1 : B0;
          cnt_d   = CNT_INIT;
          gnt0_d  = ~pick1;
          gnt1_d  = pick1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          res_d    = ALU_OUT;
          res_z_d  = ALU_Z;
          res_cf_d = ALU_CF;
          done0_d  = ~win_q;
          done1_d  = win_q;
          op_cnt_d = (op_cnt_q == 8'hFF) ? op_cnt_q : op_cnt_q + 8'd1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        sel_d   = '0;
        a_d     = '0;
        b_d     = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      win_q    <= 1'b0;
      sel_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      res_q    <= '0;
      res_z_q  <= 1'b0;
      res_cf_q <= 1'b0;
      busy_q   <= 1'b0;
      op_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      win_q    <= win_d;
      sel_q    <= sel_d;
      a_q      <= a_d;
      b_q      <= b_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      res_q    <= res_d;
      res_z_q  <= res_z_d;
      res_cf_q <= res_cf_d;
      busy_q   <= busy_d;
      op_cnt_q <= op_cnt_d;
    end
  end

  assign ALU_SEL = sel_q;
  assign ALU_A   = a_q;
  assign ALU_B   = b_q;
  assign GNT0    = gnt0_q;
  assign GNT1    = gnt1_q;
  assign DONE0   = done0_q;
  assign DONE1   = done1_q;
  assign RES     = res_q;
  assign RES_Z   = res_z_q;
  assign RES_CF  = res_cf_q;
  assign BUSY    = busy_q;
  assign OP_CNT  = op_cnt_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler: two instances (LAT=1 and LAT=3) checked every cycle
// against a transaction-timeline model, plus directed literal expectations.
module tb_alu_scheduler;

  localparam int ND = 2;
  localparam int unsigned L0 = 1;
  localparam int unsigned L1 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       req  [ND][2];
  logic [2:0] op   [ND][2];
  logic [3:0] a    [ND][2];
  logic [3:0] b    [ND][2];
  logic       gnt  [ND][2];
  logic       done [ND][2];
  logic [2:0] alu_sel [ND];
  logic [3:0] alu_a   [ND];
  logic [3:0] alu_b   [ND];
  logic [3:0] alu_out [ND];
  logic       alu_z   [ND];
  logic       alu_cf  [ND];
  logic [3:0] res     [ND];
  logic       res_z   [ND];
  logic       res_cf  [ND];
  logic       busy    [ND];
  logic [7:0] op_cnt  [ND];

  // ALU: {cf, z, out}; opcode 0 is the zero function with both flags low.
  function automatic logic [5:0] alu_fn(input logic [2:0] s, input logic [3:0] x, input logic [3:0] y);
    logic [4:0] t;
    logic [3:0] o;
    logic       c;
    c = 1'b0;
    t = '0;
    o = '0;
    case (s)
      3'd0: return 6'd0;
      3'd1: begin t = {1'b0, x} + {1'b0, y}; o = t[3:0]; c = t[4]; end
      3'd2: begin t = {1'b0, x} - {1'b0, y}; o = t[3:0]; c = t[4]; end
      3'd3: o = x & y;
      3'd4: o = x | y;
      3'd5: o = x ^ y;
      3'd6: o = ~x;
      default: o = y;
    endcase
    return {c, (o == 4'd0), o};
  endfunction

  assign {alu_cf[0], alu_z[0], alu_out[0]} = alu_fn(alu_sel[0], alu_a[0], alu_b[0]);
  assign {alu_cf[1], alu_z[1], alu_out[1]} = alu_fn(alu_sel[1], alu_a[1], alu_b[1]);

  alu_scheduler #(.LAT(L0)) u_dut_l1 (
    .CLK(clk), .RST(rst),
    .REQ0(req[0][0]), .REQ1(req[0][1]), .OP0(op[0][0]), .OP1(op[0][1]),
    .A0(a[0][0]), .B0(b[0][0]), .A1(a[0][1]), .B1(b[0][1]),
    .ALU_SEL(alu_sel[0]), .ALU_A(alu_a[0]), .ALU_B(alu_b[0]),
    .ALU_OUT(alu_out[0]), .ALU_Z(alu_z[0]), .ALU_CF(alu_cf[0]),
    .GNT0(gnt[0][0]), .GNT1(gnt[0][1]), .DONE0(done[0][0]), .DONE1(done[0][1]),
    .RES(res[0]), .RES_Z(res_z[0]), .RES_CF(res_cf[0]), .BUSY(busy[0]), .OP_CNT(op_cnt[0])
  );

  alu_scheduler #(.LAT(L1)) u_dut_l3 (
    .CLK(clk), .RST(rst),
    .REQ0(req[1][0]), .REQ1(req[1][1]), .OP0(op[1][0]), .OP1(op[1][1]),
    .A0(a[1][0]), .B0(b[1][0]), .A1(a[1][1]), .B1(b[1][1]),
    .ALU_SEL(alu_sel[1]), .ALU_A(alu_a[1]), .ALU_B(alu_b[1]),
    .ALU_OUT(alu_out[1]), .ALU_Z(alu_z[1]), .ALU_CF(alu_cf[1]),
    .GNT0(gnt[1][0]), .GNT1(gnt[1][1]), .DONE0(done[1][0]), .DONE1(done[1][1]),
    .RES(res[1]), .RES_Z(res_z[1]), .RES_CF(res_cf[1]), .BUSY(busy[1]), .OP_CNT(op_cnt[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? int'(L0) : int'(L1);
  endfunction

  // Timeline model: each accepted request owns edges [grant, grant+LAT], the
  // next request can only be sampled at grant+LAT+2.
  int         cyc = 0;
  int         m_gnt_e  [ND];
  int         m_done_e [ND];
  int         m_next   [ND];
  int         m_win    [ND];
  int         m_last   [ND];
  int         m_cnt    [ND];
  logic [2:0] m_op     [ND];
  logic [3:0] m_a      [ND];
  logic [3:0] m_b      [ND];
  logic [5:0] m_res    [ND];

  initial begin
    for (int d = 0; d < ND; d++) begin
      m_gnt_e[d] = -10; m_done_e[d] = -10; m_next[d] = 0; m_win[d] = 0;
      m_last[d] = 1; m_cnt[d] = 0; m_op[d] = '0; m_a[d] = '0; m_b[d] = '0; m_res[d] = '0;
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (rst) begin
        m_next[d] = cyc + 1; m_gnt_e[d] = -10; m_done_e[d] = -10;
        m_last[d] = 1; m_cnt[d] = 0; m_res[d] = '0;
      end else begin
        if (cyc >= m_next[d] && (req[d][0] || req[d][1])) begin
          m_win[d]    = (req[d][0] && req[d][1]) ? 1 - m_last[d] : (req[d][1] ? 1 : 0);
          m_last[d]   = m_win[d];
          m_op[d]     = op[d][m_win[d]];
          m_a[d]      = a[d][m_win[d]];
          m_b[d]      = b[d][m_win[d]];
          m_gnt_e[d]  = cyc;
          m_done_e[d] = cyc + lat_of(d);
          m_next[d]   = cyc + lat_of(d) + 2;
        end
        if (cyc == m_done_e[d]) begin
          m_res[d] = alu_fn(m_op[d], m_a[d], m_b[d]);
          if (m_cnt[d] < 255) m_cnt[d] = m_cnt[d] + 1;
        end
      end
    end
    cyc = cyc + 1;
  end

  int   checks = 0;
  int   errors = 0;
  logic hold [ND][2];
  bit   rnd_en = 1'b0;
  int   g_edge[$];
  int   g_who[$];

  task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d edge %0d got %0h exp %0h", nm, d, cyc - 1, got, exp);
    end
  endtask

  task automatic step();
    int  e;
    bit  bz;
    @(negedge clk);
    e = cyc - 1;
    for (int d = 0; d < ND; d++) begin
      bz = (e >= m_gnt_e[d]) && (e <= m_done_e[d]);
      chk("gnt0",   d, gnt[d][0],  (e == m_gnt_e[d]) && (m_win[d] == 0));
      chk("gnt1",   d, gnt[d][1],  (e == m_gnt_e[d]) && (m_win[d] == 1));
      chk("done0",  d, done[d][0], (e == m_done_e[d]) && (m_win[d] == 0));
      chk("done1",  d, done[d][1], (e == m_done_e[d]) && (m_win[d] == 1));
      chk("busy",   d, busy[d], bz);
      chk("alu_sel", d, alu_sel[d], bz ? m_op[d] : 3'd0);
      chk("alu_a",  d, alu_a[d], bz ? m_a[d] : 4'd0);
      chk("alu_b",  d, alu_b[d], bz ? m_b[d] : 4'd0);
      chk("res",    d, res[d],    m_res[d][3:0]);
      chk("res_z",  d, res_z[d],  m_res[d][4]);
      chk("res_cf", d, res_cf[d], m_res[d][5]);
      chk("op_cnt", d, op_cnt[d], m_cnt[d]);
    end
    for (int d = 0; d < ND; d++) begin
      for (int r = 0; r < 2; r++) begin
        if (req[d][r] && gnt[d][r]) begin
          if (d == 0) begin g_edge.push_back(e); g_who.push_back(r); end
          if (!hold[d][r]) req[d][r] = 1'b0;
        end
        if (rnd_en && !req[d][r] && $urandom_range(3) == 0) begin
          req[d][r] = 1'b1;
          op[d][r]  = 3'($urandom);
          a[d][r]   = 4'($urandom);
          b[d][r]   = 4'($urandom);
        end
      end
    end
  endtask

  task automatic issue(input int d, input int r, input logic [2:0] o, input logic [3:0] x, input logic [3:0] y);
    req[d][r] = 1'b1;
    op[d][r]  = o;
    a[d][r]   = x;
    b[d][r]   = y;
  endtask

  function automatic bit pending();
    for (int d = 0; d < ND; d++) begin
      if (busy[d]) return 1'b1;
      for (int r = 0; r < 2; r++) if (req[d][r]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic drain();
    int n;
    n = 0;
    while (n < 40 && pending()) begin step(); n++; end
    chk("drain_timeout", 0, pending(), 0);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int e0;
    int nd;
    int gs;
    for (int d = 0; d < ND; d++) begin
      for (int r = 0; r < 2; r++) begin
        req[d][r] = 1'b0; op[d][r] = '0; a[d][r] = '0; b[d][r] = '0; hold[d][r] = 1'b0;
      end
    end
    rst = 1'b1;
    repeat (3) step();
    for (int d = 0; d < ND; d++) begin
      chk("rst_busy", d, busy[d], 0);
      chk("rst_gnt", d, {gnt[d][0], gnt[d][1], done[d][0], done[d][1]}, 0);
      chk("rst_alu", d, {alu_sel[d], alu_a[d], alu_b[d]}, 0);
      chk("rst_res", d, {res[d], res_z[d], res_cf[d]}, 0);
      chk("rst_cnt", d, op_cnt[d], 0);
    end
    rst = 1'b0;

    // LAT=1 add 9+8 on requester 0; LAT=3 subtract 3-5 on requester 1.
    issue(0, 0, 3'd1, 4'h9, 4'h8);
    issue(1, 1, 3'd2, 4'h3, 4'h5);
    step();
    chk("t1_gnt0", 0, gnt[0][0], 1);
    chk("t4_gnt1", 1, gnt[1][1], 1);
    chk("t4_alu", 1, {alu_sel[1], alu_a[1], alu_b[1]}, {3'd2, 4'h3, 4'h5});
    step();
    chk("t1_done0", 0, done[0][0], 1);
    chk("t1_res", 0, {res[0], res_z[0], res_cf[0]}, {4'h1, 1'b0, 1'b1});
    chk("t1_cnt", 0, op_cnt[0], 1);
    chk("t4_busy2", 1, busy[1], 1);
    chk("t4_alu2", 1, {alu_sel[1], alu_a[1], alu_b[1]}, {3'd2, 4'h3, 4'h5});
    step();
    chk("t1_idle", 0, {busy[0], alu_sel[0], alu_a[0], alu_b[0]}, 0);
    chk("t4_alu3", 1, {alu_sel[1], alu_a[1], alu_b[1]}, {3'd2, 4'h3, 4'h5});
    step();
    chk("t4_done1", 1, done[1][1], 1);
    chk("t4_busy4", 1, busy[1], 1);
    chk("t4_res", 1, {res[1], res_z[1], res_cf[1]}, {4'hE, 1'b0, 1'b1});
    chk("t4_alu4", 1, {alu_sel[1], alu_a[1], alu_b[1]}, {3'd2, 4'h3, 4'h5});
    step();
    chk("t4_busy5", 1, busy[1], 0);
    drain();

    // Zero opcode.
    issue(0, 0, 3'd0, 4'hF, 4'h0);
    nd = 0;
    repeat (5) begin
      step();
      if (done[0][0]) begin
        nd++;
        chk("t2_res", 0, {res[0], res_z[0], res_cf[0]}, 0);
      end
    end
    chk("t2_done_once", 0, nd, 1);
    drain();

    // Both held after reset: alternate starting with requester 0.
    reset_pulse();
    hold[0][0] = 1'b1; hold[0][1] = 1'b1;
    issue(0, 0, 3'd5, 4'hA, 4'h3);
    issue(0, 1, 3'd1, 4'h7, 4'h7);
    gs = g_edge.size();
    e0 = cyc;
    repeat (12) step();
    hold[0][0] = 1'b0; hold[0][1] = 1'b0;
    chk("t3_ngrants", 0, g_edge.size() - gs, 4);
    if (g_edge.size() - gs >= 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("t3_edge", 0, g_edge[gs + k] - e0, 3 * k);
        chk("t3_who", 0, g_who[gs + k], k % 2);
      end
    end
    drain();

    // Reset during the last EXEC cycle of the LAT=3 instance.
    hold[1][0] = 1'b1; hold[1][1] = 1'b1;
    issue(1, 0, 3'd3, 4'hC, 4'hA);
    issue(1, 1, 3'd4, 4'h1, 4'h2);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_nodone", 1, {done[1][0], done[1][1]}, 0);
    chk("t5_res", 1, {res[1], res_z[1], res_cf[1]}, 0);
    chk("t5_cnt", 1, op_cnt[1], 0);
    chk("t5_busy", 1, busy[1], 0);
    step();
    chk("t5_regrant", 1, {gnt[1][0], gnt[1][1]}, 2'b10);
    hold[1][0] = 1'b0; hold[1][1] = 1'b0;
    drain();

    rnd_en = 1'b1;
    repeat (800) step();
    rnd_en = 1'b0;
    drain();

    // Back-to-back until the operation counter saturates.
    for (int d = 0; d < ND; d++) begin
      for (int r = 0; r < 2; r++) begin
        hold[d][r] = 1'b1;
        issue(d, r, 3'($urandom), 4'($urandom), 4'($urandom));
      end
    end
    repeat (1400) step();
    chk("t6_sat", 0, op_cnt[0], 255);
    chk("t6_sat", 1, op_cnt[1], 255);
    for (int d = 0; d < ND; d++) for (int r = 0; r < 2; r++) hold[d][r] = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
